// File: rtl/exe_muldiv.sv
// Execute stage: single-cycle ALU plus an iterative 32-step RV32M multiply/divide engine.
// state | meaning
// IDLE  | ALU ops and M-ext special cases resolve here; a normal M op is captured and starts the engine
// BUSY  | one shift-add / restoring shift-subtract step per cycle, pipeline held
// DONE  | sign-corrected engine result presented for one cycle, stall released
module exe_muldiv #(
  parameter int XLEN    = 32,
  parameter int ALUOP_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [XLEN-1:0]    op1_i,
  input  logic [XLEN-1:0]    op2_i,
  input  logic               reg_we_i,
  input  logic [4:0]         reg_waddr_i,
  input  logic [ALUOP_W-1:0] aluOp_i,
  input  logic               flush_i,
  output logic [XLEN-1:0]    reg_wdata_o,
  output logic               reg_we_o,
  output logic [4:0]         reg_waddr_o,
  output logic               stall_req_o
);

  localparam int SH_W  = $clog2(XLEN);
  localparam int CNT_W = $clog2(XLEN);

  localparam logic [ALUOP_W-1:0] OP_NOP    = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] OP_ADD    = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] OP_SUB    = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] OP_AND    = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] OP_OR     = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] OP_XOR    = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] OP_SLL    = ALUOP_W'(6);
  localparam logic [ALUOP_W-1:0] OP_SRL    = ALUOP_W'(7);
  localparam logic [ALUOP_W-1:0] OP_SRA    = ALUOP_W'(8);
  localparam logic [ALUOP_W-1:0] OP_SLT    = ALUOP_W'(9);
  localparam logic [ALUOP_W-1:0] OP_SLTU   = ALUOP_W'(10);
  localparam logic [ALUOP_W-1:0] OP_MUL    = ALUOP_W'(11);
  localparam logic [ALUOP_W-1:0] OP_MULH   = ALUOP_W'(12);
  localparam logic [ALUOP_W-1:0] OP_MULHSU = ALUOP_W'(13);
  localparam logic [ALUOP_W-1:0] OP_MULHU  = ALUOP_W'(14);
  localparam logic [ALUOP_W-1:0] OP_DIV    = ALUOP_W'(15);
  localparam logic [ALUOP_W-1:0] OP_DIVU   = ALUOP_W'(16);
  localparam logic [ALUOP_W-1:0] OP_REM    = ALUOP_W'(17);
  localparam logic [ALUOP_W-1:0] OP_REMU   = ALUOP_W'(18);

  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN-1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;     // mul: {partial hi, multiplier}; div: {remainder, quotient}
  logic [XLEN-1:0]   opb_q, opb_d;     // multiplicand or divisor magnitude
  logic              neg_q, neg_d;
  logic              is_div_q, is_div_d;
  logic              sel_hi_q, sel_hi_d;

  // opcode decode
  logic is_mul, is_div, is_multi, is_alu;
  logic op1_signed, op2_signed, is_rem, sel_hi;
  logic s1, s2;
  logic [XLEN-1:0] mag1, mag2;
  logic div_zero, div_ovf;
  logic [XLEN-1:0] special_res;

  always_comb begin
    is_mul     = (aluOp_i == OP_MUL) || (aluOp_i == OP_MULH) ||
                 (aluOp_i == OP_MULHSU) || (aluOp_i == OP_MULHU);
    is_div     = (aluOp_i == OP_DIV) || (aluOp_i == OP_DIVU) ||
                 (aluOp_i == OP_REM) || (aluOp_i == OP_REMU);
    is_multi   = is_mul || is_div;
    is_alu     = (aluOp_i >= OP_ADD) && (aluOp_i <= OP_SLTU);
    is_rem     = (aluOp_i == OP_REM) || (aluOp_i == OP_REMU);
    sel_hi     = (aluOp_i == OP_MULH) || (aluOp_i == OP_MULHSU) ||
                 (aluOp_i == OP_MULHU) || is_rem;
    op1_signed = (aluOp_i == OP_MUL) || (aluOp_i == OP_MULH) || (aluOp_i == OP_MULHSU) ||
                 (aluOp_i == OP_DIV) || (aluOp_i == OP_REM);
    op2_signed = (aluOp_i == OP_MUL) || (aluOp_i == OP_MULH) ||
                 (aluOp_i == OP_DIV) || (aluOp_i == OP_REM);
    s1         = op1_signed && op1_i[XLEN-1];
    s2         = op2_signed && op2_i[XLEN-1];
    mag1       = s1 ? -op1_i : op1_i;
    mag2       = s2 ? -op2_i : op2_i;
    div_zero   = is_div && (op2_i == '0);
    div_ovf    = ((aluOp_i == OP_DIV) || (aluOp_i == OP_REM)) &&
                 (op1_i == INT_MIN) && (op2_i == '1);
    if (div_zero)
      special_res = is_rem ? op1_i : '1;
    else
      special_res = is_rem ? '0 : INT_MIN;
  end

  logic [XLEN-1:0] alu_res;
  always_comb begin
    alu_res = '0;
    case (aluOp_i)
      OP_ADD:  alu_res = op1_i + op2_i;
      OP_SUB:  alu_res = op1_i - op2_i;
      OP_AND:  alu_res = op1_i & op2_i;
      OP_OR:   alu_res = op1_i | op2_i;
      OP_XOR:  alu_res = op1_i ^ op2_i;
      OP_SLL:  alu_res = op1_i << op2_i[SH_W-1:0];
      OP_SRL:  alu_res = op1_i >> op2_i[SH_W-1:0];
      OP_SRA:  alu_res = $signed(op1_i) >>> op2_i[SH_W-1:0];
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op1_i) < $signed(op2_i))};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op1_i < op2_i)};
      default: alu_res = '0;
    endcase
  end

  // one engine step for each kind
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     rem_sh, div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] div_next;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opb_q : {XLEN{1'b0}})};
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff = rem_sh - {1'b0, opb_q};
    div_ge   = ~div_diff[XLEN];
    div_next = {(div_ge ? div_diff[XLEN-1:0] : rem_sh[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
  end

  logic [2*XLEN-1:0] prod_signed;
  logic [XLEN-1:0]   div_mag;
  logic [XLEN-1:0]   engine_res;

  always_comb begin
    prod_signed = neg_q ? -acc_q : acc_q;
    div_mag     = sel_hi_q ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
    if (is_div_q)
      engine_res = neg_q ? -div_mag : div_mag;
    else
      engine_res = sel_hi_q ? prod_signed[2*XLEN-1:XLEN] : prod_signed[XLEN-1:0];
  end

  logic [XLEN-1:0] wdata;
  logic            we;
  logic [4:0]      waddr;
  logic            stall;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    neg_d    = neg_q;
    is_div_d = is_div_q;
    sel_hi_d = sel_hi_q;
    wdata    = '0;
    we       = 1'b0;
    waddr    = reg_waddr_i;
    stall    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (is_multi) begin
          if (div_zero || div_ovf) begin
            wdata = special_res;
            we    = reg_we_i;
          end else if (!flush_i) begin
            stall    = 1'b1;
            cnt_d    = '0;
            is_div_d = is_div;
            sel_hi_d = sel_hi;
            // remainder follows the dividend; everything else follows the product/quotient sign
            neg_d    = is_rem ? s1 : (s1 ^ s2);
            acc_d    = is_div ? {{XLEN{1'b0}}, mag1} : {{XLEN{1'b0}}, mag2};
            opb_d    = is_div ? mag2 : mag1;
            state_d  = S_BUSY;
          end
        end else begin
          wdata = alu_res;
          we    = is_alu ? reg_we_i : 1'b0;
        end
      end
      S_BUSY: begin
        stall = 1'b1;
        acc_d = is_div_q ? div_next : mul_next;
        if (cnt_q == CNT_LAST) state_d = S_DONE;
        else                   cnt_d   = cnt_q + CNT_W'(1);
      end
      S_DONE: begin
        wdata   = engine_res;
        we      = reg_we_i;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (flush_i) begin
      state_d = S_IDLE;
      stall   = 1'b0;
      we      = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      neg_q    <= 1'b0;
      is_div_q <= 1'b0;
      sel_hi_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      neg_q    <= neg_d;
      is_div_q <= is_div_d;
      sel_hi_q <= sel_hi_d;
    end
  end

  // outputs are combinational from ID/EX, so hold them at zero while reset is asserted
  assign reg_wdata_o = rst_i ? wdata : '0;
  assign reg_we_o    = rst_i ? we    : 1'b0;
  assign reg_waddr_o = rst_i ? waddr : 5'd0;
  assign stall_req_o = rst_i ? stall : 1'b0;

endmodule

// File: doc/exe_muldiv.md
Name: exe_muldiv

Overview:
- Execute stage directly downstream of the ID/EX pipeline register.
- Consumes latched operands, ALU opcode and destination register, and produces write-back data for the EX/MEM register.
- Single-cycle ALU ops resolve combinationally.
- RV32M multiply/divide ops run on an iterative 32-step engine that holds the pipeline through stall_req_o until the result is ready.

Parameters:
- XLEN, 32, operand/result width.
- ALUOP_W, 8, width of aluOp_i; opcode values are the aluOp codes in defines.v.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- op1_i  in  XLEN  operand 1 from ID/EX.
- op2_i  in  XLEN  operand 2 from ID/EX.
- reg_we_i  in  1  write enable from ID/EX.
- reg_waddr_i  in  5  destination register from ID/EX.
- aluOp_i  in  ALUOP_W  operation code from ID/EX.
- flush_i  in  1  synchronous abort of the in-flight instruction.
- reg_wdata_o  out  XLEN  result to EX/MEM.
- reg_we_o  out  1  write enable to EX/MEM.
- reg_waddr_o  out  5  destination to EX/MEM.
- stall_req_o  out  1  hold request to pipeline control (PC, IF/ID and ID/EX freeze while high).

Behaviour:
- Reset (rst_i=0, async):
  - FSM=IDLE; iteration counter=0; internal accumulators=0.
  - Outputs forced: reg_wdata_o=0, reg_we_o=0, reg_waddr_o=0, stall_req_o=0.
- Single-cycle ops (NOP, ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU):
  - Result is combinational, same cycle; no stall.
  - Shift amount = op2_i[4:0].
  - reg_we_o=reg_we_i; reg_waddr_o=reg_waddr_i.
  - NOP: reg_wdata_o=0, reg_we_o=0.
- Multi-cycle ops (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) — FSM IDLE -> BUSY -> DONE -> IDLE:
  - IDLE: on a multi-cycle op, assert stall_req_o combinationally, capture operand magnitudes and result sign into the engine, counter=0, go to BUSY.
  - BUSY: one shift-add (mul) or restoring shift-subtract (div) step per cycle. stall_req_o=1, reg_we_o=0. Leave BUSY after step 31 (counter==31).
  - DONE: stall_req_o=0; reg_wdata_o = sign-corrected result; reg_we_o=reg_we_i; reg_waddr_o=reg_waddr_i. Next state is IDLE.
  - Latency: op arrives cycle 0 -> stall high cycles 0..32 (33 cycles) -> result valid cycle 33.
- Signedness:
  - MUL returns low 32 bits of the product.
  - MULH is signed×signed, high 32 bits.
  - MULHSU is signed op1 × unsigned op2, high 32 bits.
  - MULHU is unsigned×unsigned, high 32 bits.
  - DIV/REM are signed; quotient truncates toward zero; remainder takes the sign of the dividend.
- Special cases, resolved in IDLE in a single cycle with no stall:
  - Divide by zero: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> op1_i.
  - Signed overflow (op1=0x80000000, op2=0xFFFFFFFF): DIV -> 0x80000000; REM -> 0.
- Inputs during BUSY: the ID/EX outputs are frozen by the stall. The engine uses its captured values; inputs are ignored except in DONE, where reg_we_i/reg_waddr_i are read.
- flush_i:
  - Any state -> IDLE next edge; reg_we_o=0 and stall_req_o=0 in the same cycle.
  - flush_i in IDLE with a multi-cycle op: the op does not start.
- Back-to-back multi-cycle ops: after DONE, the next instruction is seen in IDLE and starts a fresh 33-cycle sequence. DONE never restarts on the same instruction.
- Async reset mid-BUSY: immediate return to IDLE with all outputs at reset values.

Test Plan:
- ADD op1=5, op2=0xFFFFFFFD, rd=3, we=1 -> same cycle reg_wdata_o=2, reg_we_o=1, reg_waddr_o=3, stall_req_o=0.
- MUL 0x00010000 × 0x00010000 -> stall high exactly 33 cycles, then reg_wdata_o=0; MULHU with the same operands -> 0x00000001.
- DIV −7 / 2 -> 0xFFFFFFFD (−3) after 33 stall cycles; REM −7 / 2 -> 0xFFFFFFFF (−1).
- DIVU 10 / 0 -> 0xFFFFFFFF, REMU 10 / 0 -> 10, DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; all with no stall.
- flush_i at BUSY cycle 10 -> stall_req_o=0 and reg_we_o=0 that cycle; FSM IDLE next cycle; following ADD completes normally.
- rst_i low at BUSY cycle 20 -> all outputs 0 immediately; after release, a MULH −2 × 3 returns 0xFFFFFFFF with the full 33-cycle latency.
